// File: rtl/button_uart_tx_if.sv
// Button sample input and UART status bundle for button_uart_tx.
// The master drives samples; the slave (the transmitter) reports link state.
interface button_uart_tx_if;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       txd;
    logic       busy;
    logic       pkt_sent;
    logic [7:0] last_sent;

    modport master (
        output buttons,
        output buttons_valid,
        input  txd,
        input  busy,
        input  pkt_sent,
        input  last_sent
    );

    modport slave (
        input  buttons,
        input  buttons_valid,
        output txd,
        output busy,
        output pkt_sent,
        output last_sent
    );
endinterface

// File: rtl/button_uart_tx.sv
// Reports gamepad button samples as 3-byte 8N1 UART packets (header, data,
// checksum) on change or keepalive, with a single-entry newest-wins slot.
module button_uart_tx #(
    parameter int unsigned CLKS_PER_BIT     = 868,
    parameter logic [7:0]  HEADER           = 8'hA5,
    parameter int unsigned KEEPALIVE_FRAMES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    button_uart_tx_if.slave  bus
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  KA_LAST   = 8'(KEEPALIVE_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  ka_q, ka_d;
    logic        busy_q, busy_d;
    logic        pkt_q, pkt_d;
    logic        txd_q, txd_d;

    logic [7:0]  ref_val;
    logic        report;
    logic        launch;
    logic [7:0]  launch_data;
    logic        bit_end;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ka_d        = ka_q;
        busy_d      = busy_q;
        pkt_d       = 1'b0;
        txd_d       = 1'b1;
        report      = 1'b0;
        launch      = 1'b0;
        launch_data = pend_q;
        ref_val     = pend_vld_q ? pend_q : last_q;
        bit_end     = (baud_q == BAUD_LAST);

        if (bus.buttons_valid) begin
            if ((bus.buttons != ref_val) || (ka_q == KA_LAST)) begin
                report = 1'b1;
                ka_d   = '0;
            end else begin
                ka_d   = ka_q + 8'd1;
            end
        end

        if (report) begin
            pend_d     = bus.buttons;
            pend_vld_d = 1'b1;
        end

        if ((state_q == START) || (state_q == DATA) || (state_q == STOP)) begin
            baud_d = bit_end ? '0 : baud_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                // A sample queued last cycle launches now; a fresh one waits.
                if (pend_vld_q) begin
                    launch      = 1'b1;
                    launch_data = pend_q;
                    pend_vld_d  = report;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == 2'd2) begin
                        state_d = DONE;
                        pkt_d   = 1'b1;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = (byte_q == 2'd0) ? last_q : (HEADER ^ last_q);
                        state_d = START;
                    end
                end
            end
            DONE: begin
                // Includes a sample strobed in this very cycle.
                if (pend_vld_d) begin
                    launch      = 1'b1;
                    launch_data = pend_d;
                    pend_vld_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            byte_d  = '0;
            shreg_d = HEADER;
            last_d  = launch_data;
            busy_d  = 1'b1;
        end

        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shreg_q    <= '0;
            last_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ka_q       <= '0;
            busy_q     <= 1'b0;
            pkt_q      <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ka_q       <= ka_d;
            busy_q     <= busy_d;
            pkt_q      <= pkt_d;
            txd_q      <= txd_d;
        end
    end

    assign bus.txd       = txd_q;
    assign bus.busy      = busy_q;
    assign bus.pkt_sent  = pkt_q;
    assign bus.last_sent = last_q;

endmodule

// File: tb/tb_button_uart_tx.sv
// Bench for button_uart_tx: a UART byte monitor pops expected bytes
// from a scoreboard queue; scenario tasks check timing and status.
module tb_button_uart_tx;

    localparam int CPB_A  = 4;
    localparam int KA_A   = 4;
    localparam int CPB_B  = 868;
    localparam int PKT_A  = 30 * CPB_A;
    localparam int PKT_B  = 30 * CPB_B;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [9:0] mon_bits;
    logic       mon_bad;
    logic       mon_abort;
    int         mon_b;
    int         mon_c;

    button_uart_tx_if bus_a ();
    button_uart_tx_if bus_b ();

    button_uart_tx #(
        .CLKS_PER_BIT     (CPB_A),
        .HEADER           (8'hA5),
        .KEEPALIVE_FRAMES (KA_A)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    button_uart_tx #(
        .CLKS_PER_BIT     (CPB_B),
        .HEADER           (8'hA5),
        .KEEPALIVE_FRAMES (16)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART receiver for DUT A: every bit must hold for exactly CPB_A samples.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && bus_a.txd === 1'b0) begin
                mon_bad   = 1'b0;
                mon_abort = 1'b0;
                mon_bits  = '0;
                for (int k = 0; k < 10 * CPB_A; k++) begin
                    if (k != 0) @(negedge clk);
                    if (!reset_n) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_b = k / CPB_A;
                    mon_c = k % CPB_A;
                    if (mon_c == 0) mon_bits[mon_b] = bus_a.txd;
                    else if (bus_a.txd !== mon_bits[mon_b]) mon_bad = 1'b1;
                end
                if (!mon_abort) begin
                    checks++;
                    if (mon_bad || mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
                        errors++;
                        $display("FAIL uart_frame got bits=%b want start=0 stop=1 each %0d cycles",
                                 mon_bits, CPB_A);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL uart_byte got %02h want no byte", mon_bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (mon_bits[8:1] !== exp_b) begin
                            errors++;
                            $display("FAIL uart_byte got %02h want %02h", mon_bits[8:1], exp_b);
                        end
                    end
                end
            end
        end
    end

    task automatic push_pkt(input logic [7:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(d);
        exp_q.push_back(8'hA5 ^ d);
    endtask

    task automatic strobe_a(input logic [7:0] v);
        @(negedge clk);
        bus_a.buttons       = v;
        bus_a.buttons_valid = 1'b1;
        @(negedge clk);
        bus_a.buttons_valid = 1'b0;
        bus_a.buttons       = 8'($urandom);
    endtask

    task automatic test_reset;
        reset_n             = 1'b0;
        bus_a.buttons       = 8'h00;
        bus_a.buttons_valid = 1'b0;
        bus_b.buttons       = 8'h00;
        bus_b.buttons_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.txd !== 1'b1 || bus_b.txd !== 1'b1) begin
            errors++;
            $display("FAIL reset_txd got %b/%b want 1/1", bus_a.txd, bus_b.txd);
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus_a.busy);
        end
        checks++;
        if (bus_a.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL reset_pkt_sent got %b want 0", bus_a.pkt_sent);
        end
        checks++;
        if (bus_a.last_sent !== 8'h00) begin
            errors++;
            $display("FAIL reset_last_sent got %02h want 00", bus_a.last_sent);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int n;
        push_pkt(8'h01);
        strobe_a(8'h01);
        checks++;
        if (bus_a.txd !== 1'b1) begin
            errors++;
            $display("FAIL latency_early got txd=%b want 1", bus_a.txd);
        end
        @(negedge clk);
        checks++;
        if (bus_a.txd !== 1'b0 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_start got txd=%b busy=%b want 0/1", bus_a.txd, bus_a.busy);
        end
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != PKT_A) begin
            errors++;
            $display("FAIL single_length got %0d cycles want %0d", n, PKT_A);
        end
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.last_sent !== 8'h01) begin
            errors++;
            $display("FAIL single_done got busy=%b last=%02h want 1/01",
                     bus_a.busy, bus_a.last_sent);
        end
        @(negedge clk);
        checks++;
        if (bus_a.pkt_sent !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after got pkt=%b busy=%b want 0/0",
                     bus_a.pkt_sent, bus_a.busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d bytes left want 0", exp_q.size());
        end
    endtask

    task automatic test_keepalive;
        int n;
        for (int i = 1; i < KA_A; i++) begin
            strobe_a(8'h01);
            repeat (3) @(negedge clk);
            checks++;
            if (bus_a.busy !== 1'b0) begin
                errors++;
                $display("FAIL keepalive_quiet strobe %0d got busy=%b want 0", i, bus_a.busy);
            end
        end
        push_pkt(8'h01);
        strobe_a(8'h01);
        @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.txd !== 1'b0) begin
            errors++;
            $display("FAIL keepalive_fire got busy=%b txd=%b want 1/0", bus_a.busy, bus_a.txd);
        end
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL keepalive_timeout got no pkt_sent want pulse");
        end
        repeat (3) @(negedge clk);
        strobe_a(8'h01);
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL keepalive_restart got busy=%b left=%0d want 0/0",
                     bus_a.busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        push_pkt(8'h10);
        strobe_a(8'h10);
        repeat (20) @(negedge clk);
        strobe_a(8'h20);
        repeat (3) @(negedge clk);
        push_pkt(8'h40);
        strobe_a(8'h40);
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got n=%0d busy=%b want pkt_sent with busy=1", n, bus_a.busy);
        end
        @(negedge clk);
        checks++;
        if (bus_a.txd !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.pkt_sent !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got txd=%b busy=%b pkt=%b want 0/1/0",
                     bus_a.txd, bus_a.busy, bus_a.pkt_sent);
        end
        checks++;
        if (bus_a.last_sent !== 8'h40) begin
            errors++;
            $display("FAIL b2b_last got %02h want 40", bus_a.last_sent);
        end
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (n >= 400 || bus_a.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end got n=%0d busy=%b left=%0d want done/0/0",
                     n, bus_a.busy, exp_q.size());
        end
    endtask

    task automatic test_done_collision;
        int n;
        push_pkt(8'h02);
        strobe_a(8'h02);
        @(negedge clk);
        repeat (PKT_A) @(negedge clk);
        checks++;
        if (bus_a.pkt_sent !== 1'b1) begin
            errors++;
            $display("FAIL collide_done got pkt_sent=%b want 1", bus_a.pkt_sent);
        end
        bus_a.buttons       = 8'h80;
        bus_a.buttons_valid = 1'b1;
        push_pkt(8'h80);
        @(negedge clk);
        bus_a.buttons_valid = 1'b0;
        checks++;
        if (bus_a.txd !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.last_sent !== 8'h80) begin
            errors++;
            $display("FAIL collide_launch got txd=%b busy=%b last=%02h want 0/1/80",
                     bus_a.txd, bus_a.busy, bus_a.last_sent);
        end
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (60) @(negedge clk);
        checks++;
        if (n >= 400 || bus_a.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL collide_end got n=%0d busy=%b left=%0d want done/0/0",
                     n, bus_a.busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int n;
        exp_q.push_back(8'hA5);
        strobe_a(8'h08);
        @(negedge clk);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_a.txd !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.last_sent !== 8'h00) begin
            errors++;
            $display("FAIL midreset got txd=%b busy=%b last=%02h want 1/0/00",
                     bus_a.txd, bus_a.busy, bus_a.last_sent);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i < KA_A; i++) begin
            strobe_a(8'h00);
            repeat (3) @(negedge clk);
            checks++;
            if (bus_a.busy !== 1'b0 || bus_a.txd !== 1'b1) begin
                errors++;
                $display("FAIL midreset_quiet strobe %0d got busy=%b txd=%b want 0/1",
                         i, bus_a.busy, bus_a.txd);
            end
        end
        push_pkt(8'h00);
        strobe_a(8'h00);
        @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_keepalive got busy=%b want 1", bus_a.busy);
        end
        n = 0;
        while (bus_a.pkt_sent !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n >= 400 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_end got n=%0d left=%0d want done/0", n, exp_q.size());
        end
    endtask

    task automatic test_long_baud;
        int n;
        @(negedge clk);
        bus_b.buttons       = 8'h5A;
        bus_b.buttons_valid = 1'b1;
        @(negedge clk);
        bus_b.buttons_valid = 1'b0;
        n = 0;
        while (bus_b.txd !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL long_latency got %0d want 1", n);
        end
        n = 0;
        while (bus_b.pkt_sent !== 1'b1 && n < PKT_B + 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != PKT_B) begin
            errors++;
            $display("FAIL long_length got %0d cycles want %0d", n, PKT_B);
        end
        checks++;
        if (bus_b.last_sent !== 8'h5A) begin
            errors++;
            $display("FAIL long_last got %02h want 5A", bus_b.last_sent);
        end
        @(negedge clk);
        checks++;
        if (bus_b.busy !== 1'b0) begin
            errors++;
            $display("FAIL long_idle got busy=%b want 0", bus_b.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_keepalive();
        test_back_to_back();
        test_done_collision();
        test_reset_mid();
        test_long_baud();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
